cp0_regfile_p: RTL
==================

Name: cp0_regfile_p

Overview:
Parametrised second-generation CP0 register file for the MIPS pipeline, driven by WB_stage. Holds BadVAddr, Count, Compare, Status, Cause and EPC. Adds a configurable Count tick divider, a configurable hardware-interrupt count and timer line, and a registered interrupt-request output for the pipeline. Also fixes the BadVAddr capture condition and defines reset values for every register.

Parameters:
HW_INT_NUM, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+i]
TICK_DIV, 2, Count increments once every TICK_DIV clk cycles (>=1)
TI_LINE, 5, hardware IP line (0..5) that Cause.TI is ORed onto, i.e. IP[2+TI_LINE]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ext_int_in  in  HW_INT_NUM  external interrupt levels
wb_ex  in  1  exception commit from WB
wb_excode  in  5  exception code
wb_badvaddr  in  32  faulting address
wb_bd  in  1  excepting instruction is in a delay slot
wb_pc  in  32  PC of the excepting instruction
mtc0_we  in  1  MTC0 write enable
c0_addr  in  5  CP0 read/write register number
c0_wdata  in  32  MTC0 data
eret_flush  in  1  ERET commit
c0_rdata  out  32  combinational read data for MFC0
c0_epc  out  32  current EPC
c0_status_exl  out  1  current Status.EXL
int_req  out  1  registered interrupt request to the pipeline

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other address reads 0; writes to it are ignored.
- Reset values are all zero: BadVAddr, Count, Compare, IM, EXL, IE, BD, TI, IP, ExcCode, EPC, tick divider, int_req.
- Status read format: bit22 BEV=1 (constant), [15:8] IM, [1] EXL, [0] IE. All other bits read 0.
- Cause read format: [31] BD, [30] TI, [15:8] IP, [6:2] ExcCode. All other bits read 0.
- c0_rdata is combinational from c0_addr. There is no same-cycle bypass: a write becomes visible the cycle after mtc0_we.
- Priority within one cycle: wb_ex, then eret_flush, then mtc0.
  - With wb_ex: EXL is set; an MTC0 in the same cycle to Status, Cause or EPC is dropped for the fields the exception updates.
- Exception entry (wb_ex=1):
  - EXL <= 1 and ExcCode <= wb_excode, always.
  - If EXL was 0: BD <= wb_bd and EPC <= wb_bd ? wb_pc-4 : wb_pc (32-bit wrap). If EXL was 1, BD and EPC are held.
  - BadVAddr <= wb_badvaddr only when wb_excode is 4 (AdEL) or 5 (AdES).
- ERET (eret_flush=1 and wb_ex=0): EXL <= 0.
- MTC0 writes:
  - Status: IM <= wdata[15:8], EXL <= wdata[1], IE <= wdata[0].
  - Cause: only IP[1:0] <= wdata[9:8].
  - EPC, Compare and Count: full 32-bit write.
- Count:
  - A divider counter runs 0..TICK_DIV-1; Count += 1 (wrapping 0xFFFFFFFF to 0) on the cycle the divider equals TICK_DIV-1.
  - With TICK_DIV=1, Count increments every cycle.
  - An MTC0 to Count loads the value and clears the divider; no increment that cycle.
- TI:
  - Set on the cycle Count is incremented to a value equal to Compare.
  - Cleared by an MTC0 to Compare; the clear wins if both happen in the same cycle.
  - Loading Count by MTC0 never sets TI.
  - TI stays set until Compare is written.
- IP hardware bits:
  - IP[2+i] <= ext_int_in[i], registered one cycle. Unused lines read 0.
  - IP[2+TI_LINE] <= ext_int_in[TI_LINE] | TI, where TI is the registered value as of the previous cycle.
- int_req is registered: int_req <= IE & ~EXL & |(IP & IM), evaluated from current register values. It follows IE or EXL changes one cycle later.
- The block has no busy state and never stalls the pipeline.

Test Plan:
- Reset with TICK_DIV=2, then 10 idle cycles -> Status reads 0x0040_0000, Cause reads 0, Count reads 5, int_req=0.
- Delay-slot exception: wb_ex=1, excode=4, wb_pc=0xBFC0_0104, bd=1, badvaddr=0x0000_1001 -> EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1001, EXL=1. A second exception (excode 8, pc 0x2000) leaves EPC and BD unchanged, ExcCode=8, and BadVAddr stays 0x1001.
- wb_ex and eret_flush in the same cycle -> EXL=1. eret_flush alone on the next cycle -> EXL=0. MTC0 to Status with 0x0000_8001 -> IM=0x80, IE=1.
- Timer with TICK_DIV=1: write Count=0 and Compare=3 -> TI reads 1 starting the cycle after Count becomes 3, IP7 follows one cycle later. With IM=0x80 and IE=1, int_req=1 one cycle after IP7. MTC0 to Compare clears TI, and IP7 and int_req drop in turn.
- ext_int_in[0]=1 with IM=0x04, IE=1, EXL=0 -> Cause.IP2 reads 1 after 1 cycle and int_req=1 after 2 cycles. Setting EXL via an exception -> int_req=0 on the following cycle.
- MTC0 to Cause with 0x0000_0300 -> Cause reads 0x0000_0300. With IM=0x01 and IE=1, int_req=1. Writing 0xFFFF_FFFF to Cause changes only IP[1:0].

Source files
------------

// File: rtl/cp0_regfile_p.sv
// cp0_regfile_p: CP0 register file for the MIPS pipeline, updated from WB.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. Count advances
// through a TICK_DIV-cycle divider, the Count==Compare timer raises Cause.TI,
// and a registered interrupt request is offered to the pipeline.
module cp0_regfile_p #(
    parameter int HW_INT_NUM = 6,
    parameter int TICK_DIV   = 2,
    parameter int TI_LINE    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HW_INT_NUM-1:0] ext_int_in,
    input  logic                  wb_ex,
    input  logic [4:0]            wb_excode,
    input  logic [31:0]           wb_badvaddr,
    input  logic                  wb_bd,
    input  logic [31:0]           wb_pc,
    input  logic                  mtc0_we,
    input  logic [4:0]            c0_addr,
    input  logic [31:0]           c0_wdata,
    input  logic                  eret_flush,
    output logic [31:0]           c0_rdata,
    output logic [31:0]           c0_epc,
    output logic                  c0_status_exl,
    output logic                  int_req
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Divider needs at least one bit even when every cycle is a tick.
    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Architectural state
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q,    count_d;
    logic [31:0]      compare_q,  compare_d;
    logic [7:0]       im_q,       im_d;
    logic             exl_q,      exl_d;
    logic             ie_q,       ie_d;
    logic             bd_q,       bd_d;
    logic             ti_q,       ti_d;
    logic [7:0]       ip_q,       ip_d;
    logic [4:0]       excode_q,   excode_d;
    logic [31:0]      epc_q,      epc_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             int_req_q,  int_req_d;

    // Decoded MTC0 targets and helpers
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       wr_cause;
    logic       wr_epc;
    logic       tick;
    logic [5:0] ip_hw;

    // Decode which register an MTC0 targets this cycle.
    always_comb begin
        wr_count   = mtc0_we && (c0_addr == ADDR_COUNT);
        wr_compare = mtc0_we && (c0_addr == ADDR_COMPARE);
        wr_status  = mtc0_we && (c0_addr == ADDR_STATUS);
        wr_cause   = mtc0_we && (c0_addr == ADDR_CAUSE);
        wr_epc     = mtc0_we && (c0_addr == ADDR_EPC);
    end

    // Count divider, Count/Compare and the timer interrupt flag.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        count_d   = count_q;
        div_d     = div_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (wr_count) begin
            count_d = c0_wdata;
            div_d   = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Only a real tick can fire the timer; a software load of Count never does.
        if (!wr_count && tick && ((count_q + 32'd1) == compare_q)) begin
            ti_d = 1'b1;
        end

        // Writing Compare acknowledges the timer and beats a same-cycle match.
        if (wr_compare) begin
            compare_d = c0_wdata;
            ti_d      = 1'b0;
        end
    end

    // Cause.IP: hardware lines sampled each cycle, software lines via MTC0.
    always_comb begin
        ip_hw          = 6'(ext_int_in);
        ip_hw[TI_LINE] = ip_hw[TI_LINE] | ti_q;
        ip_d           = {ip_hw, (wr_cause ? c0_wdata[9:8] : ip_q[1:0])};
    end

    // Status, exception entry, ERET and EPC/BadVAddr capture.
    always_comb begin
        im_d       = im_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        bd_d       = bd_q;
        excode_d   = excode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (wr_status) begin
            im_d  = c0_wdata[15:8];
            ie_d  = c0_wdata[0];
            exl_d = c0_wdata[1];
        end

        if (wr_epc && !wb_ex) begin
            epc_d = c0_wdata;
        end

        if (eret_flush && !wb_ex) begin
            exl_d = 1'b0;
        end

        // Exception overrides any same-cycle ERET or MTC0 on the fields it owns.
        if (wb_ex) begin
            exl_d    = 1'b1;
            excode_d = wb_excode;
            if (!exl_q) begin
                bd_d  = wb_bd;
                epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
            if ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES)) begin
                badvaddr_d = wb_badvaddr;
            end
        end
    end

    // Interrupt request built from the current register values.
    always_comb begin
        int_req_d = ie_q && !exl_q && (|(ip_q & im_q));
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            excode_q   <= '0;
            epc_q      <= '0;
            div_q      <= '0;
            int_req_q  <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            excode_q   <= excode_d;
            epc_q      <= epc_d;
            div_q      <= div_d;
            int_req_q  <= int_req_d;
        end
    end

    // MFC0 read mux, combinational from c0_addr.
    always_comb begin
        c0_rdata = '0;
        unique case (c0_addr)
            ADDR_BADVADDR: c0_rdata = badvaddr_q;
            ADDR_COUNT:    c0_rdata = count_q;
            ADDR_COMPARE:  c0_rdata = compare_q;
            ADDR_STATUS:   c0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            ADDR_CAUSE:    c0_rdata = {bd_q, ti_q, 14'd0, ip_q, 1'b0, excode_q, 2'd0};
            ADDR_EPC:      c0_rdata = epc_q;
            default:       c0_rdata = '0;
        endcase
    end

    // Direct register views for the pipeline.
    always_comb begin
        c0_epc        = epc_q;
        c0_status_exl = exl_q;
        int_req       = int_req_q;
    end

endmodule
